adaptive_binarization: RTL and testbench

ADAPTIVE_BINARIZATION -- requirements
Module: adaptive_binarization

---
 rtl/adaptive_binarization.sv | 195 +++++++++++++++++++
 tb/tb_adaptive_binarization.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/adaptive_binarization.sv
// Luminance binarizer with fixed / inverted / window / adaptive-mean thresholds.
// The adaptive mean of frame N becomes the threshold for frames after it.
module adaptive_binarization #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 21,
  parameter int TH_DEF = 220
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pre_vsync,
  input  logic              pre_href,
  input  logic              pre_de,
  input  logic [DATA_W-1:0] pre_data,
  input  logic [1:0]        cfg_mode,
  input  logic [DATA_W-1:0] cfg_th_lo,
  input  logic [DATA_W-1:0] cfg_th_hi,
  input  logic [DATA_W:0]   cfg_offset,
  output logic              post_vsync,
  output logic              post_href,
  output logic              post_de,
  output logic              monoc,
  output logic [DATA_W-1:0] th_active,
  output logic              th_valid
);
  localparam int SUM_W = DATA_W + CNT_W;
  localparam int DCW   = $clog2(SUM_W);

  typedef enum logic [1:0] {IDLE, ACC, DIV, DONE} state_t;

  state_t            state_q, state_d;
  logic              vsync_q, href_q, de_q, monoc_q, monoc_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] th_hi_q, th_hi_d;
  logic [DATA_W:0]   offset_q, offset_d;
  logic [DATA_W-1:0] th_active_q, th_active_d;
  logic [DATA_W-1:0] th_store_q, th_store_d;
  logic              th_valid_q, th_valid_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SUM_W-1:0]  num_q, num_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [DCW-1:0]    div_cnt_q, div_cnt_d;

  logic frame_start, frame_end;
  logic acc_en, div_load, div_run, commit;
  logic [CNT_W:0]    rem_sh, rem_sub;
  logic              div_ge;
  logic signed [DATA_W+1:0] th_sum;

  assign frame_start = pre_vsync & ~vsync_q;
  assign frame_end   = ~pre_vsync & vsync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (frame_start) state_d = ACC;
      ACC:  if (frame_end) state_d = (cnt_q == '0) ? IDLE : DIV;
      DIV:  if (div_cnt_q == DCW'(SUM_W - 1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // a new frame always wins, aborting any division in flight
    if (frame_start) state_d = ACC;
  end

  always_comb begin
    acc_en   = 1'b0;
    div_load = 1'b0;
    div_run  = 1'b0;
    commit   = 1'b0;
    case (state_q)
      ACC:  begin acc_en = pre_de; div_load = frame_end; end
      DIV:  div_run = 1'b1;
      DONE: commit = 1'b1;
      default: ;
    endcase
  end

  assign rem_sh  = {rem_q, num_q[SUM_W-1]};
  assign rem_sub = rem_sh - {1'b0, cnt_q};
  assign div_ge  = rem_sh >= {1'b0, cnt_q};
  assign th_sum  = $signed({2'b00, quo_q}) + $signed({offset_q[DATA_W], offset_q});

  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    if (frame_start) begin
      sum_d = '0;
      cnt_d = '0;
    end else if (acc_en && cnt_q != '1) begin
      sum_d = sum_q + SUM_W'(pre_data);
      cnt_d = cnt_q + CNT_W'(1);
    end

    num_d     = num_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    div_cnt_d = div_cnt_q;
    if (div_load) begin
      num_d     = sum_q;
      quo_d     = '0;
      rem_d     = '0;
      div_cnt_d = '0;
    end else if (div_run) begin
      num_d     = num_q << 1;
      quo_d     = {quo_q[DATA_W-2:0], div_ge};
      rem_d     = div_ge ? rem_sub[CNT_W-1:0] : rem_sh[CNT_W-1:0];
      div_cnt_d = div_cnt_q + DCW'(1);
    end

    th_store_d = th_store_q;
    th_valid_d = th_valid_q;
    if (commit) begin
      th_valid_d = 1'b1;
      if (th_sum < 0)
        th_store_d = '0;
      else if (th_sum > $signed({2'b00, {DATA_W{1'b1}}}))
        th_store_d = '1;
      else
        th_store_d = th_sum[DATA_W-1:0];
    end

    mode_d      = mode_q;
    th_hi_d     = th_hi_q;
    offset_d    = offset_q;
    th_active_d = th_active_q;
    if (frame_start) begin
      mode_d      = cfg_mode;
      th_hi_d     = cfg_th_hi;
      offset_d    = cfg_offset;
      th_active_d = (cfg_mode == 2'b11 && th_valid_q) ? th_store_q : cfg_th_lo;
    end

    monoc_d = 1'b0;
    if (pre_de) begin
      case (mode_q)
        2'b00:   monoc_d = pre_data > th_active_q;
        2'b01:   monoc_d = pre_data <= th_active_q;
        2'b10:   monoc_d = (pre_data >= th_active_q) && (pre_data <= th_hi_q);
        default: monoc_d = pre_data > th_active_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      de_q        <= 1'b0;
      monoc_q     <= 1'b0;
      mode_q      <= 2'b00;
      th_hi_q     <= '0;
      offset_q    <= '0;
      th_active_q <= DATA_W'(TH_DEF);
      th_store_q  <= DATA_W'(TH_DEF);
      th_valid_q  <= 1'b0;
      sum_q       <= '0;
      cnt_q       <= '0;
      num_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      div_cnt_q   <= '0;
    end else begin
      vsync_q     <= pre_vsync;
      href_q      <= pre_href;
      de_q        <= pre_de;
      monoc_q     <= monoc_d;
      mode_q      <= mode_d;
      th_hi_q     <= th_hi_d;
      offset_q    <= offset_d;
      th_active_q <= th_active_d;
      th_store_q  <= th_store_d;
      th_valid_q  <= th_valid_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      div_cnt_q   <= div_cnt_d;
    end
  end

  assign post_vsync = vsync_q;
  assign post_href  = href_q;
  assign post_de    = de_q;
  assign monoc      = monoc_q;
  assign th_active  = th_active_q;
  assign th_valid   = th_valid_q;
endmodule

// File: tb/tb_adaptive_binarization.sv
// Bench for adaptive_binarization: table rows, directed adaptive/abort/reset
// sequences and random frames checked against a frame-level mean model.
module tb_adaptive_binarization;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pre_vsync = 1'b0, pre_href = 1'b0, pre_de = 1'b0;
  logic [7:0] pre_data = '0;
  logic [1:0] cfg_mode = '0;
  logic [7:0] cfg_th_lo = '0, cfg_th_hi = '0;
  logic [8:0] cfg_offset = '0;
  logic       post_vsync, post_href, post_de, monoc, th_valid;
  logic [7:0] th_active;

  adaptive_binarization #(.DATA_W(8), .CNT_W(21), .TH_DEF(220)) dut (
    .clk(clk), .rst_n(rst_n), .pre_vsync(pre_vsync), .pre_href(pre_href),
    .pre_de(pre_de), .pre_data(pre_data), .cfg_mode(cfg_mode),
    .cfg_th_lo(cfg_th_lo), .cfg_th_hi(cfg_th_hi), .cfg_offset(cfg_offset),
    .post_vsync(post_vsync), .post_href(post_href), .post_de(post_de),
    .monoc(monoc), .th_active(th_active), .th_valid(th_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode; int lo; int hi; int d; int exp;
  } vec_t;
  vec_t tbl[11];

  int n_cmp = 0, n_err = 0;
  int m_store = 220, m_th = 220, m_mode = 0, m_hi = 0;
  bit m_valid = 1'b0;
  int last_mono = 0;
  int pix_q[$];

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic int ref_mono(input int mode, input int d, input int lo, input int hi);
    case (mode)
      0: return int'(d > lo);
      1: return int'(d <= lo);
      2: return int'(lo <= d && d <= hi);
      default: return int'(d > lo);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One frame: rising vsync, pixels from pix_q, falling vsync, then idle
  // so the next rising edge lands 'gap' cycles after the frame end.
  task automatic run_frame(input int mode, input int lo, input int hi, input int off, input int gap);
    int sum = 0, n = 0;
    cfg_mode = 2'(mode); cfg_th_lo = 8'(lo); cfg_th_hi = 8'(hi); cfg_offset = 9'(off);
    pre_vsync = 1'b1; pre_href = 1'b0; pre_de = 1'b0;
    m_mode = mode; m_hi = hi;
    m_th = (mode == 3 && m_valid) ? m_store : lo;
    tick();
    chk("post_vsync", int'(post_vsync), 1);
    chk("th_active", int'(th_active), m_th);
    cfg_mode = 2'($urandom); cfg_th_lo = 8'($urandom);
    cfg_th_hi = 8'($urandom); cfg_offset = 9'($urandom);
    foreach (pix_q[i]) begin
      pre_href = 1'b1; pre_de = 1'b1; pre_data = 8'(pix_q[i]);
      tick();
      chk("post_de", int'(post_de), 1);
      chk("monoc", int'(monoc), ref_mono(m_mode, pix_q[i], m_th, m_hi));
      last_mono = int'(monoc);
      sum += pix_q[i]; n++;
    end
    pre_href = 1'b0; pre_de = 1'b0;
    tick();
    chk("monoc_idle", int'(monoc), 0);
    pre_vsync = 1'b0;
    tick();
    repeat (gap - 1) tick();
    if (n > 0 && gap >= 40) begin
      m_store = clamp(sum / n + off);
      m_valid = 1'b1;
    end
    chk("th_valid", int'(th_valid), int'(m_valid));
  endtask

  initial begin
    tbl[0]  = '{0, 100, 0, 99, 0};
    tbl[1]  = '{0, 100, 0, 100, 0};
    tbl[2]  = '{0, 100, 0, 101, 1};
    tbl[3]  = '{1, 100, 0, 100, 1};
    tbl[4]  = '{1, 100, 0, 101, 0};
    tbl[5]  = '{2, 50, 60, 49, 0};
    tbl[6]  = '{2, 50, 60, 50, 1};
    tbl[7]  = '{2, 50, 60, 60, 1};
    tbl[8]  = '{2, 50, 60, 61, 0};
    tbl[9]  = '{2, 70, 60, 65, 0};
    tbl[10] = '{2, 70, 60, 70, 0};

    tick(); tick();
    chk("rst_post_vsync", int'(post_vsync), 0);
    chk("rst_post_de", int'(post_de), 0);
    chk("rst_monoc", int'(monoc), 0);
    chk("rst_th_active", int'(th_active), 220);
    chk("rst_th_valid", int'(th_valid), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      pix_q = '{tbl[i].d};
      run_frame(tbl[i].mode, tbl[i].lo, tbl[i].hi, 0, 5);
      chk($sformatf("tbl%0d", i), last_mono, tbl[i].exp);
    end

    // adaptive: mean 25 + 5 = 30, then 31 is white
    pix_q = '{10, 20, 30, 40};
    run_frame(3, 100, 0, 5, 40);
    chk("adapt_valid", int'(th_valid), 1);
    pix_q = '{30, 31};
    run_frame(3, 0, 0, -50, 40);
    chk("adapt_th30", int'(th_active), 30);
    chk("adapt_pix31", last_mono, 1);

    // mean 30 - 50 saturates low; mean 200 + 100 saturates high
    pix_q = '{200, 200, 200, 200};
    run_frame(3, 0, 0, 100, 40);
    chk("sat_low", int'(th_active), 0);
    pix_q = {};
    run_frame(3, 0, 0, 0, 40);
    chk("sat_high", int'(th_active), 255);

    // empty frame kept 255; then a division aborted by an early vsync
    pix_q = '{100, 100};
    run_frame(3, 0, 0, 0, 5);
    chk("empty_keep", int'(th_active), 255);
    pix_q = {};
    run_frame(3, 0, 0, 0, 40);
    chk("abort_keep", int'(th_active), 255);
    chk("abort_valid", int'(th_valid), 1);

    // reset mid-accumulation
    cfg_mode = 2'b00; cfg_th_lo = 8'd10;
    pre_vsync = 1'b1; tick();
    pre_href = 1'b1; pre_de = 1'b1; pre_data = 8'd77;
    tick(); tick();
    rst_n = 1'b0; #1;
    chk("mrst_post_vsync", int'(post_vsync), 0);
    chk("mrst_post_href", int'(post_href), 0);
    chk("mrst_post_de", int'(post_de), 0);
    chk("mrst_monoc", int'(monoc), 0);
    chk("mrst_th_active", int'(th_active), 220);
    chk("mrst_th_valid", int'(th_valid), 0);
    m_store = 220; m_valid = 1'b0;
    pre_vsync = 1'b0; pre_href = 1'b0; pre_de = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    pix_q = '{60, 80};
    run_frame(0, 10, 0, 0, 40);
    pix_q = {};
    run_frame(3, 0, 0, 0, 40);
    chk("post_rst_mean", int'(th_active), 70);

    for (int f = 0; f < 10; f++) begin
      int np;
      np = int'($urandom_range(0, 10));
      pix_q = {};
      for (int k = 0; k < np; k++) pix_q.push_back(int'($urandom_range(0, 255)));
      run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 511)) - 256,
                ($urandom_range(0, 2) == 0) ? 5 : 40);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
